// File: rtl/sram_mem_controller_pkg.sv
// Shared types and constants for the memory-stage SRAM access controller.
package sram_mem_controller_pkg;

    // Controller states; values match the legacy 3-bit encodings.
    typedef enum logic [2:0] {
        SMC_IDLE  = 3'd0,
        SMC_RD_HI = 3'd1,
        SMC_RD_LO = 3'd2,
        SMC_WR_HI = 3'd3,
        SMC_WR_LO = 3'd4,
        SMC_DONE  = 3'd5
    } smc_state_e;

    localparam logic [31:0] SMC_DEFAULT_ADDR_BASE = 32'd1024;
    localparam int unsigned SMC_DEFAULT_WAIT      = 5;

    // Half 0 carries the upper 16 bits of the word, half 1 the lower 16.
    function automatic logic [15:0] smc_half_select(input logic [31:0] word, input logic half);
        return half ? word[15:0] : word[31:16];
    endfunction

endpackage

// File: rtl/sram_mem_controller_if.sv
// Pipeline-side request/response and SRAM pin bundle for the controller.
interface sram_mem_controller_if #(
    parameter int unsigned SRAM_ADDR_W = 18
);
    logic                   mem_read;
    logic                   mem_write;
    logic [31:0]            address;
    logic [31:0]            data;
    logic [31:0]            result;
    logic                   ready;
    logic [SRAM_ADDR_W-1:0] sram_addr;
    logic [15:0]            sram_dq_out;
    logic [15:0]            sram_dq_in;
    logic                   sram_we_n;
    logic                   sram_oe_n;

    // Controller side.
    modport slave (
        input  mem_read, mem_write, address, data, sram_dq_in,
        output result, ready, sram_addr, sram_dq_out, sram_we_n, sram_oe_n
    );

    // Pipeline plus SRAM environment side.
    modport master (
        output mem_read, mem_write, address, data, sram_dq_in,
        input  result, ready, sram_addr, sram_dq_out, sram_we_n, sram_oe_n
    );
endinterface

// File: rtl/sram_mem_controller_wait_counter.sv
// Wait-state counter: counts clocks within one SRAM half-word phase.
module wait_counter #(
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam logic [3:0] TC_VALUE = 4'(WAIT_CYCLES - 1);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Next count: clear has priority over increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 4'd1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == TC_VALUE);

endmodule

// File: rtl/sram_mem_controller.sv
// Memory-stage controller: splits each 32-bit load/store into two
// half-word async SRAM cycles and freezes the pipeline while busy.
module sram_mem_controller
    import sram_mem_controller_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = SMC_DEFAULT_WAIT,
    parameter logic [31:0] ADDR_BASE   = SMC_DEFAULT_ADDR_BASE,
    parameter int unsigned SRAM_ADDR_W = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_mem_controller_if.slave  bus
);
    smc_state_e  state_q, state_d;
    logic [31:0] result_q, result_d;
    logic [15:0] hi_q, hi_d;

    logic        tc;
    logic        rd_phase;
    logic        wr_phase;
    logic        phase_active;
    logic        half;
    logic [31:0] addr_off;
    logic [29:0] word_idx;

    assign rd_phase     = (state_q == SMC_RD_HI) || (state_q == SMC_RD_LO);
    assign wr_phase     = (state_q == SMC_WR_HI) || (state_q == SMC_WR_LO);
    assign phase_active = rd_phase || wr_phase;
    assign half         = (state_q == SMC_RD_LO) || (state_q == SMC_WR_LO);

    // Byte offset is dropped; out-of-range addresses wrap through truncation.
    assign addr_off = bus.address - ADDR_BASE;
    assign word_idx = addr_off[31:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_off[1:0], word_idx[29:SRAM_ADDR_W-1]};

    // Counter restarts at every phase boundary and whenever no phase is running.
    wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .clr_i (!phase_active || tc),
        .en_i  (phase_active),
        .tc_o  (tc)
    );

    // Next-state logic: write wins over read when both are requested.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SMC_IDLE: begin
                if (bus.mem_write) begin
                    state_d = SMC_WR_HI;
                end else if (bus.mem_read) begin
                    state_d = SMC_RD_HI;
                end
            end
            SMC_RD_HI: if (tc) state_d = SMC_RD_LO;
            SMC_RD_LO: if (tc) state_d = SMC_DONE;
            SMC_WR_HI: if (tc) state_d = SMC_WR_LO;
            SMC_WR_LO: if (tc) state_d = SMC_DONE;
            SMC_DONE:  state_d = SMC_IDLE;
            default:   state_d = SMC_IDLE;
        endcase
    end

    // SRAM pin drive and pipeline handshake, decoded from the current state.
    always_comb begin
        bus.sram_we_n   = 1'b1;
        bus.sram_oe_n   = 1'b1;
        bus.sram_dq_out = '0;
        bus.sram_addr   = '0;
        if (rd_phase) begin
            bus.sram_oe_n = 1'b0;
            bus.sram_addr = {word_idx[SRAM_ADDR_W-2:0], half};
        end
        if (wr_phase) begin
            bus.sram_we_n   = 1'b0;
            bus.sram_addr   = {word_idx[SRAM_ADDR_W-2:0], half};
            bus.sram_dq_out = smc_half_select(bus.data, half);
        end
        bus.ready = (state_q == SMC_DONE) ||
                    ((state_q == SMC_IDLE) && !bus.mem_read && !bus.mem_write);
    end

    // Read capture: upper half is staged so result only changes when a read completes.
    always_comb begin
        hi_d     = hi_q;
        result_d = result_q;
        if ((state_q == SMC_RD_HI) && tc) begin
            hi_d = bus.sram_dq_in;
        end
        if ((state_q == SMC_RD_LO) && tc) begin
            result_d = {hi_q, bus.sram_dq_in};
        end
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= SMC_IDLE;
            result_q <= '0;
            hi_q     <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            hi_q     <= hi_d;
        end
    end

    assign bus.result = result_q;

endmodule
